// File: rtl/iterative_divider_pkg.sv
// Shared types for the iterative divider: FSM state encoding and request/response
// records at the core's native data width.
package divider_params;

    localparam int CPU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        WAITING = 2'd0,
        LOAD    = 2'd1,
        DIVIDE  = 2'd2,
        RETURN  = 2'd3
    } State;

    typedef struct packed {
        logic                      is_signed;
        logic [CPU_DATA_WIDTH-1:0] dividend;
        logic [CPU_DATA_WIDTH-1:0] divisor;
    } DividerRequest;

    typedef struct packed {
        logic [CPU_DATA_WIDTH-1:0] quotient;
        logic [CPU_DATA_WIDTH-1:0] remainder;
        logic                      divide_by_zero;
    } DividerResponse;

endpackage

// File: rtl/iterative_divider_if.sv
// Request/response handshake bundle of the iterative divider; master is the issuing
// pipeline stage, slave is the divider.
interface iterative_divider_if #(
    parameter int DATA_WIDTH = divider_params::CPU_DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_signed;
    logic [DATA_WIDTH-1:0] in_dividend;
    logic [DATA_WIDTH-1:0] in_divisor;
    logic                  cancel;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_quotient;
    logic [DATA_WIDTH-1:0] out_remainder;
    logic                  out_divide_by_zero;

    modport master (
        output in_valid, in_signed, in_dividend, in_divisor, cancel, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_divide_by_zero
    );

    modport slave (
        input  in_valid, in_signed, in_dividend, in_divisor, cancel, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_divide_by_zero
    );
endinterface

// File: rtl/iterative_divider_radix_step.sv
// One combinational restoring-division step retiring BITS_PER_CYCLE quotient bits,
// most significant first.
module divider_radix_step #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [DATA_WIDTH-1:0]     partial_remainder,
    input  logic [BITS_PER_CYCLE-1:0] dividend_bits,
    input  logic [DATA_WIDTH-1:0]     divisor,
    output logic [DATA_WIDTH-1:0]     next_remainder,
    output logic [BITS_PER_CYCLE-1:0] quotient_bits
);
    // One extra bit so the shifted remainder never overflows before the compare.
    logic [DATA_WIDTH:0] rem_s;
    logic [DATA_WIDTH:0] trial_s;

    // Chain of shift / trial-subtract / restore stages.
    always_comb begin
        rem_s         = {1'b0, partial_remainder};
        trial_s       = '0;
        quotient_bits = '0;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            trial_s = {rem_s[DATA_WIDTH-1:0], dividend_bits[i]};
            if (trial_s >= {1'b0, divisor}) begin
                rem_s            = trial_s - {1'b0, divisor};
                quotient_bits[i] = 1'b1;
            end else begin
                rem_s            = trial_s;
                quotient_bits[i] = 1'b0;
            end
        end
        next_remainder = rem_s[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed/unsigned divider (MIPS DIV/DIVU semantics) with valid/ready on both sides.
// Define DIVIDER_EARLY_EXIT_EN to skip the dividend's leading zero digits.
module iterative_divider
    import divider_params::*;
#(
    parameter int DATA_WIDTH     = CPU_DATA_WIDTH,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clock,
    input  logic               reset,
    iterative_divider_if.slave bus
);
    localparam int ITERATIONS  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int COUNT_WIDTH = $clog2(ITERATIONS + 1);

    State                     state_r;
    State                     next_state_s;
    logic                     accept_s;
    logic                     signed_r;
    logic [DATA_WIDTH-1:0]    dividend_r;
    logic [DATA_WIDTH-1:0]    divisor_r;
    logic                     q_neg_r;
    logic                     r_neg_r;
    logic                     div_zero_r;
    logic [DATA_WIDTH-1:0]    work_r;
    logic [DATA_WIDTH-1:0]    rem_r;
    logic [DATA_WIDTH-1:0]    div_mag_r;
    logic [COUNT_WIDTH-1:0]   iter_r;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic [DATA_WIDTH-1:0]    quotient_r;
    logic [DATA_WIDTH-1:0]    remainder_r;
    logic                     divide_by_zero_r;

    logic                     a_neg_s;
    logic                     b_neg_s;
    logic [DATA_WIDTH-1:0]    a_mag_s;
    logic [DATA_WIDTH-1:0]    b_mag_s;
    int                       pre_shift_s;
    logic [COUNT_WIDTH-1:0]   load_iter_s;
    logic [DATA_WIDTH-1:0]    step_rem_s;
    logic [BITS_PER_CYCLE-1:0] step_q_s;
    logic [DATA_WIDTH-1:0]    result_q_s;
    logic [DATA_WIDTH-1:0]    result_r_s;

`ifdef DIVIDER_EARLY_EXIT_EN
    function automatic int leading_zeros(input logic [DATA_WIDTH-1:0] value);
        int count;
        count = DATA_WIDTH;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (value[i]) begin
                count = DATA_WIDTH - 1 - i;
            end else begin
                count = count;
            end
        end
        return count;
    endfunction
`endif

    // Operand signs and magnitudes from the latched request.
    always_comb begin
        a_neg_s = signed_r & dividend_r[DATA_WIDTH-1];
        b_neg_s = signed_r & divisor_r[DATA_WIDTH-1];
        a_mag_s = a_neg_s ? -dividend_r : dividend_r;
        b_mag_s = b_neg_s ? -divisor_r : divisor_r;
    end

    // Iteration budget; early exit drops whole leading-zero digits of the dividend.
    always_comb begin
`ifdef DIVIDER_EARLY_EXIT_EN
        pre_shift_s = (leading_zeros(a_mag_s) / BITS_PER_CYCLE) * BITS_PER_CYCLE;
`else
        pre_shift_s = 32'sd0;
`endif
        load_iter_s = COUNT_WIDTH'((DATA_WIDTH - pre_shift_s) / BITS_PER_CYCLE);
    end

    divider_radix_step #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .partial_remainder (rem_r),
        .dividend_bits     (work_r[DATA_WIDTH-1 -: BITS_PER_CYCLE]),
        .divisor           (div_mag_r),
        .next_remainder    (step_rem_s),
        .quotient_bits     (step_q_s)
    );

    // Next-state logic; cancel overrides every state including a pending accept.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        if (bus.cancel) begin
            next_state_s = WAITING;
        end else begin
            case (state_r)
                WAITING: begin
                    if (bus.in_valid && in_ready_r) begin
                        accept_s     = 1'b1;
                        next_state_s = LOAD;
                    end else begin
                        next_state_s = WAITING;
                    end
                end
                LOAD: begin
                    if ((divisor_r == '0) || (load_iter_s == '0)) begin
                        next_state_s = RETURN;
                    end else begin
                        next_state_s = DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (iter_r == COUNT_WIDTH'(1)) begin
                        next_state_s = RETURN;
                    end else begin
                        next_state_s = DIVIDE;
                    end
                end
                RETURN: begin
                    if (out_valid_r && bus.out_ready) begin
                        next_state_s = WAITING;
                    end else begin
                        next_state_s = RETURN;
                    end
                end
                default: next_state_s = WAITING;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= WAITING;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture on the input handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            signed_r   <= 1'b0;
            dividend_r <= '0;
            divisor_r  <= '0;
        end else if (accept_s) begin
            signed_r   <= bus.in_signed;
            dividend_r <= bus.in_dividend;
            divisor_r  <= bus.in_divisor;
        end
    end

    // work_r starts as the (pre-shifted) dividend magnitude and fills with quotient bits
    // from the bottom, so it holds the full quotient magnitude after the last step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work_r     <= '0;
            rem_r      <= '0;
            div_mag_r  <= '0;
            iter_r     <= '0;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (state_r == LOAD) begin
            work_r     <= a_mag_s << pre_shift_s;
            rem_r      <= '0;
            div_mag_r  <= b_mag_s;
            iter_r     <= load_iter_s;
            q_neg_r    <= a_neg_s ^ b_neg_s;
            r_neg_r    <= a_neg_s;
            div_zero_r <= (divisor_r == '0);
        end else if (state_r == DIVIDE) begin
            work_r <= {work_r[DATA_WIDTH-BITS_PER_CYCLE-1:0], step_q_s};
            rem_r  <= step_rem_s;
            iter_r <= iter_r - COUNT_WIDTH'(1);
        end
    end

    // Signed fix-up; divide by zero reports the raw dividend as remainder.
    always_comb begin
        if (div_zero_r) begin
            result_q_s = '1;
            result_r_s = dividend_r;
        end else begin
            result_q_s = q_neg_r ? -work_r : work_r;
            result_r_s = r_neg_r ? -rem_r : rem_r;
        end
    end

    // Output registers; results survive cancel, only the valid flag is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_ready_r       <= 1'b1;
            out_valid_r      <= 1'b0;
            quotient_r       <= '0;
            remainder_r      <= '0;
            divide_by_zero_r <= 1'b0;
        end else begin
            in_ready_r <= (next_state_s == WAITING);
            if (bus.cancel) begin
                out_valid_r <= 1'b0;
            end else if ((state_r == RETURN) && !out_valid_r) begin
                out_valid_r      <= 1'b1;
                quotient_r       <= result_q_s;
                remainder_r      <= result_r_s;
                divide_by_zero_r <= div_zero_r;
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready           = in_ready_r;
    assign bus.out_valid          = out_valid_r;
    assign bus.out_quotient       = quotient_r;
    assign bus.out_remainder      = remainder_r;
    assign bus.out_divide_by_zero = divide_by_zero_r;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: a radix-2 and a radix-16 instance, directed
// corner cases plus random operands, scoreboarded against a behavioural reference.
module tb_iterative_divider;
    import divider_params::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    iterative_divider_if #(.DATA_WIDTH(32)) bus1 ();
    iterative_divider_if #(.DATA_WIDTH(32)) bus4 ();

    iterative_divider #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    iterative_divider #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    int             vectors     = 0;
    int             miscompares = 0;
    DividerResponse sb[$];

    task automatic check(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic rdy(input int u);
        return (u == 0) ? bus1.in_ready : bus4.in_ready;
    endfunction

    function automatic logic vld(input int u);
        return (u == 0) ? bus1.out_valid : bus4.out_valid;
    endfunction

    function automatic DividerResponse resp(input int u);
        DividerResponse r;
        if (u == 0) begin
            r.quotient       = bus1.out_quotient;
            r.remainder      = bus1.out_remainder;
            r.divide_by_zero = bus1.out_divide_by_zero;
        end else begin
            r.quotient       = bus4.out_quotient;
            r.remainder      = bus4.out_remainder;
            r.divide_by_zero = bus4.out_divide_by_zero;
        end
        return r;
    endfunction

    task automatic drive(input int u, input logic v, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (u == 0) begin
            bus1.in_valid = v; bus1.in_signed = s; bus1.in_dividend = a; bus1.in_divisor = b;
        end else begin
            bus4.in_valid = v; bus4.in_signed = s; bus4.in_dividend = a; bus4.in_divisor = b;
        end
    endtask

    task automatic set_ready(input int u, input logic r);
        if (u == 0) bus1.out_ready = r; else bus4.out_ready = r;
    endtask

    task automatic set_cancel(input int u, input logic c);
        if (u == 0) bus1.cancel = c; else bus4.cancel = c;
    endtask

    // Reference: SV integer division truncates toward zero, remainder follows dividend.
    function automatic DividerResponse ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        DividerResponse r;
        longint         sa;
        longint         sbv;
        if (b == 32'd0) begin
            r.quotient = 32'hFFFFFFFF; r.remainder = a; r.divide_by_zero = 1'b1;
        end else if (sgn) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            r.quotient = 32'(sa / sbv); r.remainder = 32'(sa % sbv); r.divide_by_zero = 1'b0;
        end else begin
            r.quotient = a / b; r.remainder = a % b; r.divide_by_zero = 1'b0;
        end
        return r;
    endfunction

    function automatic int exp_lat(input int u, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int          s;
        int          sig;
        logic [31:0] mag;
        s   = (u == 0) ? 1 : 4;
        sig = 0;
        mag = (sgn && a[31]) ? (32'd0 - a) : a;
        for (int i = 0; i < 32; i++) if (mag[i]) sig = i + 1;
        if (b == 32'd0) return 2;
`ifdef DIVIDER_EARLY_EXIT_EN
        if (sig == 0) return 2;
        return (sig + s - 1) / s + 2;
`else
        return 32 / s + 2;
`endif
    endfunction

    // One request/response transaction, optionally holding out_ready low for 'hold' cycles.
    task automatic run_op(input int u, input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
        DividerResponse e;
        int             cyc;
        int             lat;
        cyc = 0;
        while (!rdy(u) && cyc < 100) begin
            @(posedge clock); @(negedge clock); cyc++;
        end
        check("in_ready_idle", rdy(u), 1'b1);
        drive(u, 1'b1, sgn, a, b);
        sb.push_back(ref_div(sgn, a, b));
        lat = exp_lat(u, sgn, a, b);
        @(posedge clock); @(negedge clock);
        drive(u, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc = 0;
        while (!vld(u) && cyc < 200) begin
            @(posedge clock); @(negedge clock); cyc++;
        end
        check("latency", cyc, lat);
        e = sb.pop_front();
        check("in_ready_busy", rdy(u), 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); @(negedge clock);
            check("hold_valid", vld(u), 1'b1);
            check("hold_resp", resp(u), e);
            check("hold_in_ready", rdy(u), 1'b0);
        end
        check("resp", resp(u), e);
        set_ready(u, 1'b1);
        @(posedge clock); @(negedge clock);
        set_ready(u, 1'b0);
        check("drain_valid", vld(u), 1'b0);
        check("ready_after", rdy(u), 1'b1);
    endtask

    DividerRequest  req;
    DividerResponse held;
    logic           seen;
    int             cyc;

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            drive(u, 1'b0, 1'b0, 32'd0, 32'd0);
            set_ready(u, 1'b0);
            set_cancel(u, 1'b0);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            check("reset_in_ready", rdy(u), 1'b1);
            check("reset_out_valid", vld(u), 1'b0);
            check("reset_resp", resp(u), 65'd0);
        end
        reset = 1'b0;
        @(negedge clock);

        run_op(0, 1'b0, 32'd100, 32'd7, 0);
        run_op(0, 1'b1, 32'hFFFFFFF9, 32'd2, 0);
        run_op(0, 1'b1, 32'd7, 32'hFFFFFFFE, 10);
        run_op(0, 1'b0, 32'h12345678, 32'd0, 0);
        run_op(0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(1, 1'b0, 32'd5, 32'd3, 0);
        run_op(1, 1'b0, 32'd0, 32'd9, 0);
        run_op(1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 3);
        run_op(1, 1'b1, 32'hFFFFFFF9, 32'd0, 0);

        for (int n = 0; n < 24; n++) begin
            req.is_signed = 1'($urandom_range(0, 1));
            req.dividend  = $urandom >> $urandom_range(0, 31);
            req.divisor   = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) req.dividend = 32'd0 - req.dividend;
            if ($urandom_range(0, 3) == 0) req.divisor = 32'd0 - req.divisor;
            if ($urandom_range(0, 7) == 0) req.divisor = 32'd0;
            run_op(n % 2, req.is_signed, req.dividend, req.divisor, n % 3);
        end

        // Cancel mid-DIVIDE with a competing request on the same edge.
        drive(0, 1'b1, 1'b0, 32'd1000, 32'd3);
        @(posedge clock); @(negedge clock);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("cancel_busy", rdy(0), 1'b0);
        repeat (5) @(posedge clock);
        @(negedge clock);
        set_cancel(0, 1'b1);
        drive(0, 1'b1, 1'b0, 32'd50, 32'd5);
        @(posedge clock); @(negedge clock);
        set_cancel(0, 1'b0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("cancel_in_ready", rdy(0), 1'b1);
        check("cancel_out_valid", vld(0), 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); @(negedge clock);
            if (vld(0)) seen = 1'b1;
        end
        check("cancel_no_result", seen, 1'b0);

        // Cancel while a result is held: valid drops, result registers keep their value.
        held = ref_div(1'b0, 32'd50, 32'd5);
        drive(1, 1'b1, 1'b0, 32'd50, 32'd5);
        @(posedge clock); @(negedge clock);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc = 0;
        while (!vld(1) && cyc < 100) begin
            @(posedge clock); @(negedge clock); cyc++;
        end
        check("held_valid", vld(1), 1'b1);
        set_cancel(1, 1'b1);
        @(posedge clock); @(negedge clock);
        set_cancel(1, 1'b0);
        check("held_cancel_valid", vld(1), 1'b0);
        check("held_cancel_ready", rdy(1), 1'b1);
        check("held_cancel_resp", resp(1), held);

        // Reset in the middle of an operation.
        drive(0, 1'b1, 1'b0, 32'd999, 32'd7);
        @(posedge clock); @(negedge clock);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset_valid", vld(0), 1'b0);
        check("midreset_ready", rdy(0), 1'b1);
        check("midreset_resp", resp(0), 65'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); @(negedge clock);
            if (vld(0)) seen = 1'b1;
        end
        check("midreset_no_result", seen, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
